// File: rtl/init_command_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : init_command_sequencer_if
// Brief   : CPU write port plus configuration/command outputs of the sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface init_command_sequencer_if;
  logic       write_bar;
  logic       chip_select_bar;
  logic       A0;
  logic [7:0] internal_bus;

  logic       init_done;
  logic [4:0] vector_base;
  logic       ltim;
  logic       single_mode;
  logic [7:0] cascade_cfg;
  logic       upm;
  logic       aeoi;
  logic       master_sel;
  logic       buffered_mode;
  logic       sfnm;
  logic [7:0] imr;
  logic       ocw2_valid;
  logic [2:0] ocw2_cmd;
  logic [2:0] ocw2_level;
  logic       read_isr;
  logic       poll_cmd;
  logic       special_mask;

  modport master (
    output write_bar, chip_select_bar, A0, internal_bus,
    input  init_done, vector_base, ltim, single_mode, cascade_cfg,
           upm, aeoi, master_sel, buffered_mode, sfnm, imr,
           ocw2_valid, ocw2_cmd, ocw2_level, read_isr, poll_cmd, special_mask
  );

  modport slave (
    input  write_bar, chip_select_bar, A0, internal_bus,
    output init_done, vector_base, ltim, single_mode, cascade_cfg,
           upm, aeoi, master_sel, buffered_mode, sfnm, imr,
           ocw2_valid, ocw2_cmd, ocw2_level, read_isr, poll_cmd, special_mask
  );
endinterface

`default_nettype wire

// File: rtl/init_command_sequencer.sv
//------------------------------------------------------------------------------
// Module  : init_command_sequencer
// Brief   : 8259A ICW1..ICW4 init sequencer and OCW1/2/3 command decoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module init_command_sequencer #(
  parameter logic [7:0] RESET_IMR = 8'hFF
) (
  input  wire logic                    clk,
  input  wire logic                    reset_bar,
  init_command_sequencer_if.slave      bus
);

  typedef enum logic [2:0] {
    WAIT_ICW1 = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic       r_wr_q;
  logic       r_a0_q;
  logic [7:0] r_data_q;
  logic       r_ic4;

  logic       r_ltim;
  logic       r_single_mode;
  logic [4:0] r_vector_base;
  logic [7:0] r_cascade_cfg;
  logic [4:0] r_icw4;
  logic [7:0] r_imr;
  logic       r_ocw2_valid;
  logic [2:0] r_ocw2_cmd;
  logic [2:0] r_ocw2_level;
  logic       r_read_isr;
  logic       r_poll_cmd;
  logic       r_special_mask;

  logic       w_wr_active;
  logic       w_commit;
  logic       w_is_icw1;
  logic       w_is_ocw2;
  logic       w_is_ocw3;
  logic       w_ld_icw1;
  logic       w_ld_icw2;
  logic       w_ld_icw3;
  logic       w_ld_icw4;
  logic       w_ld_ocw1;
  logic       w_ld_ocw2;
  logic       w_ld_ocw3;

  assign w_wr_active = ~bus.write_bar & ~bus.chip_select_bar;
  // A write takes effect on the first edge that sees the strobe gone.
  assign w_commit    = r_wr_q & ~w_wr_active;
  assign w_is_icw1   = ~r_a0_q & r_data_q[4];
  assign w_is_ocw2   = ~r_a0_q & ~r_data_q[4] & ~r_data_q[3];
  assign w_is_ocw3   = ~r_a0_q & ~r_data_q[4] &  r_data_q[3];

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_wr_q   <= 1'b0;
      r_a0_q   <= 1'b0;
      r_data_q <= 8'h00;
    end else begin
      r_wr_q <= w_wr_active;
      if (w_wr_active) begin
        r_a0_q   <= bus.A0;
        r_data_q <= bus.internal_bus;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state <= WAIT_ICW1;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ld_icw1    = 1'b0;
    w_ld_icw2    = 1'b0;
    w_ld_icw3    = 1'b0;
    w_ld_icw4    = 1'b0;
    w_ld_ocw1    = 1'b0;
    w_ld_ocw2    = 1'b0;
    w_ld_ocw3    = 1'b0;
    if (w_commit) begin
      if (w_is_icw1) begin
        w_ld_icw1    = 1'b1;
        w_state_next = WAIT_ICW2;
      end else if (r_a0_q) begin
        case (r_state)
          WAIT_ICW2: begin
            w_ld_icw2 = 1'b1;
            if (!r_single_mode) w_state_next = WAIT_ICW3;
            else if (r_ic4)     w_state_next = WAIT_ICW4;
            else                w_state_next = READY;
          end
          WAIT_ICW3: begin
            w_ld_icw3    = 1'b1;
            w_state_next = r_ic4 ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            w_ld_icw4    = 1'b1;
            w_state_next = READY;
          end
          READY:     w_ld_ocw1 = 1'b1;
          default:   ;
        endcase
      end else if (r_state == READY) begin
        w_ld_ocw2 = w_is_ocw2;
        w_ld_ocw3 = w_is_ocw3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_ic4          <= 1'b0;
      r_ltim         <= 1'b0;
      r_single_mode  <= 1'b0;
      r_vector_base  <= 5'd0;
      r_cascade_cfg  <= 8'h00;
      r_icw4         <= 5'd0;
      r_imr          <= RESET_IMR;
      r_ocw2_valid   <= 1'b0;
      r_ocw2_cmd     <= 3'd0;
      r_ocw2_level   <= 3'd0;
      r_read_isr     <= 1'b0;
      r_poll_cmd     <= 1'b0;
      r_special_mask <= 1'b0;
    end else begin
      r_ocw2_valid <= w_ld_ocw2;
      r_poll_cmd   <= w_ld_ocw3 & r_data_q[2];
      if (w_ld_icw1) begin
        r_ltim         <= r_data_q[3];
        r_single_mode  <= r_data_q[1];
        r_ic4          <= r_data_q[0];
        r_imr          <= 8'h00;
        r_cascade_cfg  <= 8'h00;
        r_icw4         <= 5'd0;
        r_special_mask <= 1'b0;
        r_read_isr     <= 1'b0;
      end
      if (w_ld_icw2) r_vector_base <= r_data_q[7:3];
      if (w_ld_icw3) r_cascade_cfg <= r_data_q;
      if (w_ld_icw4) r_icw4        <= r_data_q[4:0];
      if (w_ld_ocw1) r_imr         <= r_data_q;
      if (w_ld_ocw2) begin
        r_ocw2_cmd   <= r_data_q[7:5];
        r_ocw2_level <= r_data_q[2:0];
      end
      if (w_ld_ocw3) begin
        if (r_data_q[1]) r_read_isr     <= r_data_q[0];
        if (r_data_q[6]) r_special_mask <= r_data_q[5];
      end
    end
  end

  assign bus.init_done     = (r_state == READY);
  assign bus.vector_base   = r_vector_base;
  assign bus.ltim          = r_ltim;
  assign bus.single_mode   = r_single_mode;
  assign bus.cascade_cfg   = r_cascade_cfg;
  assign bus.upm           = r_icw4[0];
  assign bus.aeoi          = r_icw4[1];
  assign bus.master_sel    = r_icw4[2];
  assign bus.buffered_mode = r_icw4[3];
  assign bus.sfnm          = r_icw4[4];
  assign bus.imr           = r_imr;
  assign bus.ocw2_valid    = r_ocw2_valid;
  assign bus.ocw2_cmd      = r_ocw2_cmd;
  assign bus.ocw2_level    = r_ocw2_level;
  assign bus.read_isr      = r_read_isr;
  assign bus.poll_cmd      = r_poll_cmd;
  assign bus.special_mask  = r_special_mask;

endmodule

`default_nettype wire

// File: tb/tb_init_command_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_init_command_sequencer
// Brief   : Self-checking bench: write-vector table plus hand-built corner cases.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_init_command_sequencer;

  typedef struct {
    string      name;
    logic       a0;
    logic [7:0] d;
    logic       init;
    logic [4:0] vb;
    logic       ltim;
    logic       sngl;
    logic [7:0] cas;
    logic [4:0] icw4;   // {sfnm, buffered_mode, master_sel, aeoi, upm}
    logic [7:0] imr;
    logic       v2;
    logic [2:0] cmd;
    logic [2:0] lvl;
    logic       risr;
    logic       poll;
    logic       smm;
  } vec_t;

  logic clk;
  logic reset_bar;
  int   n_checks;
  int   n_fail;
  vec_t exp_q[$];
  vec_t tbl[$];
  vec_t cur;

  init_command_sequencer_if bus ();

  init_command_sequencer #(.RESET_IMR(8'hFF)) dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic a0, input logic [7:0] d,
                              input logic init, input logic [4:0] vb, input logic ltim,
                              input logic sngl, input logic [7:0] cas, input logic [4:0] icw4,
                              input logic [7:0] imr, input logic v2, input logic [2:0] cmd,
                              input logic [2:0] lvl, input logic risr, input logic poll,
                              input logic smm);
    vec_t v;
    v.name = name; v.a0 = a0; v.d = d; v.init = init; v.vb = vb; v.ltim = ltim;
    v.sngl = sngl; v.cas = cas; v.icw4 = icw4; v.imr = imr; v.v2 = v2; v.cmd = cmd;
    v.lvl = lvl; v.risr = risr; v.poll = poll; v.smm = smm;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input vec_t e);
    check({e.name, ".init_done"},    8'(bus.init_done),    8'(e.init));
    check({e.name, ".vector_base"},  8'(bus.vector_base),  8'(e.vb));
    check({e.name, ".ltim"},         8'(bus.ltim),         8'(e.ltim));
    check({e.name, ".single_mode"},  8'(bus.single_mode),  8'(e.sngl));
    check({e.name, ".cascade_cfg"},  bus.cascade_cfg,      e.cas);
    check({e.name, ".icw4"},         8'({bus.sfnm, bus.buffered_mode, bus.master_sel,
                                          bus.aeoi, bus.upm}), 8'(e.icw4));
    check({e.name, ".imr"},          bus.imr,              e.imr);
    check({e.name, ".ocw2_valid"},   8'(bus.ocw2_valid),   8'(e.v2));
    check({e.name, ".ocw2_cmd"},     8'(bus.ocw2_cmd),     8'(e.cmd));
    check({e.name, ".ocw2_level"},   8'(bus.ocw2_level),   8'(e.lvl));
    check({e.name, ".read_isr"},     8'(bus.read_isr),     8'(e.risr));
    check({e.name, ".poll_cmd"},     8'(bus.poll_cmd),     8'(e.poll));
    check({e.name, ".special_mask"}, 8'(bus.special_mask), 8'(e.smm));
  endtask

  task automatic pop_compare();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = exp_q.pop_front();
      cmp(e);
    end
  endtask

  // One sampled-active edge, release, then compare just after the commit edge.
  task automatic do_write(input vec_t e);
    exp_q.push_back(e);
    @(negedge clk);
    bus.write_bar = 1'b0; bus.chip_select_bar = 1'b0;
    bus.A0 = e.a0; bus.internal_bus = e.d;
    @(negedge clk);
    bus.write_bar = 1'b1; bus.chip_select_bar = 1'b1;
    @(negedge clk);
    pop_compare();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_bar = 1'b0;
    bus.write_bar = 1'b1; bus.chip_select_bar = 1'b1;
    bus.A0 = 1'b0; bus.internal_bus = 8'h00;

    //          name                 a0    d      init vb     lt   sg   cas    icw4   imr    v2   cmd  lvl  risr poll smm
    tbl.push_back(mk("a0_in_wait_icw1",   1, 8'h55, 0, 5'h00, 0, 0, 8'h00, 5'h00, 8'hFF, 0, 3'd0, 3'd0, 0, 0, 0));
    tbl.push_back(mk("ocw2_in_wait_icw1", 0, 8'h20, 0, 5'h00, 0, 0, 8'h00, 5'h00, 8'hFF, 0, 3'd0, 3'd0, 0, 0, 0));
    tbl.push_back(mk("icw1_single",       0, 8'h12, 0, 5'h00, 0, 1, 8'h00, 5'h00, 8'h00, 0, 3'd0, 3'd0, 0, 0, 0));
    tbl.push_back(mk("icw2_single",       1, 8'h40, 1, 5'h08, 0, 1, 8'h00, 5'h00, 8'h00, 0, 3'd0, 3'd0, 0, 0, 0));
    tbl.push_back(mk("ocw1",              1, 8'hA5, 1, 5'h08, 0, 1, 8'h00, 5'h00, 8'hA5, 0, 3'd0, 3'd0, 0, 0, 0));
    tbl.push_back(mk("ocw2_eoi",          0, 8'h20, 1, 5'h08, 0, 1, 8'h00, 5'h00, 8'hA5, 1, 3'd1, 3'd0, 0, 0, 0));
    tbl.push_back(mk("ocw3_rr_isr",       0, 8'h0B, 1, 5'h08, 0, 1, 8'h00, 5'h00, 8'hA5, 0, 3'd1, 3'd0, 1, 0, 0));
    tbl.push_back(mk("ocw3_poll",         0, 8'h0C, 1, 5'h08, 0, 1, 8'h00, 5'h00, 8'hA5, 0, 3'd1, 3'd0, 1, 1, 0));
    tbl.push_back(mk("ocw3_smm",          0, 8'h68, 1, 5'h08, 0, 1, 8'h00, 5'h00, 8'hA5, 0, 3'd1, 3'd0, 1, 0, 1));
    tbl.push_back(mk("ocw2_rotate",       0, 8'hE3, 1, 5'h08, 0, 1, 8'h00, 5'h00, 8'hA5, 1, 3'd7, 3'd3, 1, 0, 1));
    tbl.push_back(mk("icw1_cascade",      0, 8'h11, 0, 5'h08, 0, 0, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("icw2_cascade",      1, 8'h08, 0, 5'h01, 0, 0, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("ocw2_mid_init",     0, 8'h20, 0, 5'h01, 0, 0, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("icw3",              1, 8'h04, 0, 5'h01, 0, 0, 8'h04, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("icw4_upm_aeoi",     1, 8'h03, 1, 5'h01, 0, 0, 8'h04, 5'h03, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("reinit_icw1_a",     0, 8'h11, 0, 5'h01, 0, 0, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("reinit_icw2_a",     1, 8'h08, 0, 5'h01, 0, 0, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("reinit_icw1_b",     0, 8'h13, 0, 5'h01, 0, 1, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("icw2_to_icw4",      1, 8'h20, 0, 5'h04, 0, 1, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("icw4_upper_fields", 1, 8'h1C, 1, 5'h04, 0, 1, 8'h00, 5'h1C, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("icw1_ltim",         0, 8'h1A, 0, 5'h04, 1, 1, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("icw2_direct_ready", 1, 8'hF8, 1, 5'h1F, 1, 1, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("ocw3_smm_set",      0, 8'h68, 1, 5'h1F, 1, 1, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 1));
    tbl.push_back(mk("ocw3_smm_clear",    0, 8'h48, 1, 5'h1F, 1, 1, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));
    tbl.push_back(mk("ocw3_rr_isr_2",     0, 8'h0B, 1, 5'h1F, 1, 1, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 1, 0, 0));
    tbl.push_back(mk("ocw3_rr_irr",       0, 8'h0A, 1, 5'h1F, 1, 1, 8'h00, 5'h00, 8'h00, 0, 3'd7, 3'd3, 0, 0, 0));

    // Reset state
    repeat (2) @(negedge clk);
    exp_q.push_back(mk("reset", 0, 8'h00, 0, 5'h00, 0, 0, 8'h00, 5'h00, 8'hFF, 0, 3'd0, 3'd0, 0, 0, 0));
    pop_compare();
    reset_bar = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      do_write(tbl[i]);
      cur = tbl[i];
    end

    // Long strobe: data changes while held, only the last value lands, once.
    cur.name = "long_strobe"; cur.a0 = 1'b1; cur.d = 8'h3C; cur.imr = 8'h3C;
    exp_q.push_back(cur);
    @(negedge clk);
    bus.write_bar = 1'b0; bus.chip_select_bar = 1'b0; bus.A0 = 1'b1; bus.internal_bus = 8'h11;
    @(negedge clk);
    bus.internal_bus = 8'h22;
    check("long_strobe_hold_imr", bus.imr, 8'h00);
    @(negedge clk);
    bus.internal_bus = 8'h3C;
    check("long_strobe_hold_imr2", bus.imr, 8'h00);
    @(negedge clk);
    bus.write_bar = 1'b1; bus.chip_select_bar = 1'b1;
    @(negedge clk);
    pop_compare();

    // Pulse widths
    cur.name = "ocw2_pulse"; cur.a0 = 1'b0; cur.d = 8'h20; cur.v2 = 1'b1; cur.cmd = 3'd1; cur.lvl = 3'd0;
    do_write(cur);
    @(negedge clk);
    check("ocw2_valid_one_cycle", 8'(bus.ocw2_valid), 8'h00);
    cur.v2 = 1'b0;
    cur.name = "poll_pulse"; cur.d = 8'h0C; cur.poll = 1'b1;
    do_write(cur);
    @(negedge clk);
    check("poll_cmd_one_cycle", 8'(bus.poll_cmd), 8'h00);
    cur.poll = 1'b0;

    // Chip select released while write_bar stays low ends the write.
    cur.name = "cs_release"; cur.a0 = 1'b1; cur.d = 8'h5A; cur.imr = 8'h5A;
    exp_q.push_back(cur);
    @(negedge clk);
    bus.write_bar = 1'b0; bus.chip_select_bar = 1'b0; bus.A0 = 1'b1; bus.internal_bus = 8'h5A;
    @(negedge clk);
    bus.chip_select_bar = 1'b1;
    @(negedge clk);
    pop_compare();
    bus.write_bar = 1'b1;

    // Reset during an active strobe; the strobe commits only at its own end.
    @(negedge clk);
    bus.write_bar = 1'b0; bus.chip_select_bar = 1'b0; bus.A0 = 1'b0; bus.internal_bus = 8'h12;
    @(negedge clk);
    #2 reset_bar = 1'b0;
    #1;
    exp_q.push_back(mk("reset_mid_write", 0, 8'h12, 0, 5'h00, 0, 0, 8'h00, 5'h00, 8'hFF, 0, 3'd0, 3'd0, 0, 0, 0));
    pop_compare();
    @(negedge clk);
    reset_bar = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("no_commit_after_reset_imr%0d", k), bus.imr, 8'hFF);
      check($sformatf("no_commit_after_reset_sngl%0d", k), 8'(bus.single_mode), 8'h00);
    end
    exp_q.push_back(mk("commit_after_reset", 0, 8'h12, 0, 5'h00, 0, 1, 8'h00, 5'h00, 8'h00, 0, 3'd0, 3'd0, 0, 0, 0));
    bus.write_bar = 1'b1; bus.chip_select_bar = 1'b1;
    @(negedge clk);
    pop_compare();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/init_command_sequencer.md
# init_command_sequencer

Clocked stage directly downstream of the 8259A read/write logic. It watches CPU write strobes on the internal bus, sequences the ICW1→ICW2→(ICW3)→(ICW4) initialization protocol, and holds the resulting configuration registers. After initialization it decodes OCW1/OCW2/OCW3 writes into a mask register, one-cycle command pulses and mode bits for the priority resolver and in-service logic.

## Interface
- RESET_IMR, 8'hFF, IMR value at reset; masks all levels until software initializes the device.
- clk  in  1  system clock; all state updates on its rising edge.
- reset_bar  in  1  asynchronous active-low reset.
- write_bar  in  1  CPU write strobe, active low, synchronous to clk.
- chip_select_bar  in  1  chip select, active low.
- A0  in  1  address bit qualifying the written word.
- internal_bus  in  8  write data.
- init_done  out  1  initialization sequence complete.
- vector_base  out  5  ICW2[7:3].
- ltim  out  1  ICW1[3], level-triggered mode.
- single_mode  out  1  ICW1[1] (SNGL).
- cascade_cfg  out  8  ICW3 contents.
- upm, aeoi, master_sel, buffered_mode, sfnm  out  1 each  ICW4[0], [1], [2], [3], [4].
- imr  out  8  interrupt mask register (OCW1).
- ocw2_valid  out  1  one-cycle pulse on an OCW2 commit.
- ocw2_cmd  out  3  OCW2[7:5] (R, SL, EOI); held until the next OCW2.
- ocw2_level  out  3  OCW2[2:0]; held until the next OCW2.
- read_isr  out  1  status read select: 0 = IRR, 1 = ISR.
- poll_cmd  out  1  one-cycle pulse when OCW3[2] (P) = 1.
- special_mask  out  1  special mask mode.

## Operation
- wr_active = ~write_bar & ~chip_select_bar.
- On every edge, wr_q <= wr_active. While wr_active = 1, a0_q <= A0 and data_q <= internal_bus, so the last sampled value wins.
- commit = wr_q & ~wr_active. All decoding uses a0_q and data_q, evaluated on the commit edge.
- Word classification on commit:
  - a0_q=0 & d[4]=1 → ICW1.
  - a0_q=0 & d[4:3]=00 → OCW2.
  - a0_q=0 & d[4:3]=01 → OCW3.
  - a0_q=1 → the sequence word or OCW1, depending on state.
- FSM states: WAIT_ICW1 (reset), WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. init_done = 1 only in READY.
- ICW1 is accepted in any state:
  - Store ltim and single_mode; latch IC4 = d[0].
  - Clear imr to 8'h00, cascade_cfg to 0, all ICW4 fields to 0, special_mask to 0 and read_isr to 0.
  - Go to WAIT_ICW2.
- WAIT_ICW2 with A0=1: vector_base <= d[7:3]. Next state: WAIT_ICW3 if SNGL=0; else WAIT_ICW4 if IC4=1; else READY.
- WAIT_ICW3 with A0=1: cascade_cfg <= d. Next state: WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW4 with A0=1: store the ICW4 fields and go to READY. Bits [7:5] are ignored.
- Commits that do not match the current state are ignored, with no state change:
  - A0=1 in WAIT_ICW1.
  - Any OCW-class write before READY.
- READY, A0=1: imr <= d (OCW1).
- READY, OCW2:
  - ocw2_cmd <= d[7:5] and ocw2_level <= d[2:0].
  - ocw2_valid = 1 for exactly one cycle.
- READY, OCW3:
  - If d[1] (RR) = 1, read_isr <= d[0]; otherwise read_isr is unchanged.
  - If d[6] (ESMM) = 1, special_mask <= d[5]; otherwise special_mask is unchanged.
  - If d[2] = 1, poll_cmd = 1 for one cycle.

## Timing
- Reset values:
  - State WAIT_ICW1; wr_q, a0_q and data_q are 0.
  - init_done = 0, vector_base = 0, ltim = 0, single_mode = 0, cascade_cfg = 0.
  - All ICW4 outputs = 0; imr = RESET_IMR.
  - ocw2_valid = 0, ocw2_cmd = 0, ocw2_level = 0.
  - read_isr = 0, poll_cmd = 0, special_mask = 0.
- Write strobe handling:
  - The write must be active for at least one sampled edge.
  - Outputs update on the first edge at which wr_active is sampled 0 after being sampled 1 (commit edge), and are visible immediately after that edge.
  - Latency is 1 clock from strobe deassertion.
- A continuous write strobe commits once, at its end. Back-to-back writes need one inactive sampled edge between them.
- Deasserting chip_select_bar mid-strobe also ends the write and commits.
- Asserting reset_bar mid-write clears wr_q. No commit occurs after reset is released, even if the strobe is still active at release; that write then commits at its own end.
- ocw2_valid and poll_cmd are registered pulses, high only during the cycle after the commit edge.

## Test plan
- Single mode, no ICW4: ICW1 0x12, then ICW2 (A0=1) 0x40 → init_done=1 after the ICW2 commit; vector_base=5'b01000, cascade_cfg=0x00, aeoi=0, imr=0x00.
- Cascade with ICW4: ICW1 0x11, ICW2 0x08, ICW3 0x04, ICW4 0x03 → init_done stays 0 until the ICW4 commit; cascade_cfg=0x04, upm=1, aeoi=1, vector_base=5'b00001.
- Ignored writes before init: A0=1 0x55 and OCW2 0x20 in WAIT_ICW1 → imr=0xFF, ocw2_valid never pulses. After init, OCW1 0xA5 → imr=0xA5 one edge after strobe release.
- OCW decode in READY:
  - 0x20 → ocw2_valid high one cycle, ocw2_cmd=3'b001, ocw2_level=0.
  - 0x0B → read_isr=1.
  - 0x0C → poll_cmd pulses one cycle, read_isr stays 1.
  - 0x68 → special_mask=1.
- Re-init mid-sequence: ICW1 0x11, ICW2 0x08, then ICW1 0x13 → state WAIT_ICW2, init_done=0, imr=0x00. Next, ICW2 0x20 → state WAIT_ICW4 (SNGL=1, IC4=1).
- Reset during an active write strobe → every output at its reset value; no commit on the first edges after release while the strobe stays high. The strobe's later release commits normally.
